// File: rtl/branch_resolve_queue.sv
// In-order queue of resolved branches between the branch unit and the ROB writeback port.
// Emits a one-cycle fetch redirect when a taken branch drains, and raises stall before the queue can overflow.
module branch_resolve_queue #(
    parameter int unsigned          DEPTH       = 4,
    parameter int unsigned          TAG_W       = 4,
    parameter int unsigned          DATA_W      = 32,
    parameter logic [TAG_W-1:0]     TAG_INVALID = {TAG_W{1'b1}}
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [TAG_W-1:0]         in_tag,
    input  logic                     in_taken,
    input  logic [DATA_W-1:0]        in_next_pc,
    input  logic                     flush,
    output logic                     wb_valid,
    input  logic                     wb_ready,
    output logic [TAG_W-1:0]         wb_tag,
    output logic                     wb_taken,
    output logic [DATA_W-1:0]        wb_pc,
    output logic                     redirect_valid,
    output logic [DATA_W-1:0]        redirect_pc,
    output logic                     stall,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [TAG_W-1:0]  tag_mem_q   [DEPTH];
    logic [TAG_W-1:0]  tag_mem_d   [DEPTH];
    logic              taken_mem_q [DEPTH];
    logic              taken_mem_d [DEPTH];
    logic [DATA_W-1:0] pc_mem_q    [DEPTH];
    logic [DATA_W-1:0] pc_mem_d    [DEPTH];

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              redirect_valid_q, redirect_valid_d;
    logic [DATA_W-1:0] redirect_pc_q, redirect_pc_d;
    logic              overflow_q, overflow_d;

    logic              empty;
    logic              push_req;
    logic              pop;
    logic              push_ok;

    assign empty    = (count_q == '0);
    assign push_req = (in_tag != TAG_INVALID);
    assign pop      = !empty && wb_ready;
    // A full queue can still take a push when the head leaves at the same edge.
    assign push_ok  = push_req && ((count_q < CNT_W'(DEPTH)) || pop);

    always_comb begin
        head_d           = head_q;
        tail_d           = tail_q;
        count_d          = count_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        overflow_d       = overflow_q;
        tag_mem_d        = tag_mem_q;
        taken_mem_d      = taken_mem_q;
        pc_mem_d         = pc_mem_q;

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (pop) begin
                head_d = head_q + 1'b1;
                if (taken_mem_q[head_q]) begin
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = pc_mem_q[head_q];
                end
            end
            if (push_ok) begin
                tag_mem_d[tail_q]   = in_tag;
                taken_mem_d[tail_q] = in_taken;
                pc_mem_d[tail_q]    = in_next_pc;
                tail_d              = tail_q + 1'b1;
            end else if (push_req) begin
                overflow_d = 1'b1;
            end
            count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            overflow_q       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_mem_q[i]   <= TAG_INVALID;
                taken_mem_q[i] <= 1'b0;
                pc_mem_q[i]    <= '0;
            end
        end else begin
            head_q           <= head_d;
            tail_q           <= tail_d;
            count_q          <= count_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            overflow_q       <= overflow_d;
            for (int i = 0; i < DEPTH; i++) begin
                tag_mem_q[i]   <= tag_mem_d[i];
                taken_mem_q[i] <= taken_mem_d[i];
                pc_mem_q[i]    <= pc_mem_d[i];
            end
        end
    end

    // Head is presented straight from storage; an empty queue shows the idle pattern.
    assign wb_valid       = !empty;
    assign wb_tag         = empty ? TAG_INVALID : tag_mem_q[head_q];
    assign wb_taken       = empty ? 1'b0        : taken_mem_q[head_q];
    assign wb_pc          = empty ? '0          : pc_mem_q[head_q];

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign stall          = (count_q >= CNT_W'(DEPTH - 1));
    assign count          = count_q;
    assign overflow       = overflow_q;

endmodule
